gray_seq_ctrl: RTL and testbench
================================

GRAY_SEQ_CTRL -- requirements
Module: gray_seq_ctrl

Interface
REQ-001 Parameter: WIDTH, default 4, code width in bits (legal range 2..16).
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 Port: start  input  1  request a new sequence; sampled only in IDLE.
REQ-005 Port: b_start  input  WIDTH  binary value of the first code; latched when start is accepted.
REQ-006 Port: len  input  WIDTH  number of codes to emit minus one; latched when start is accepted.
REQ-007 Port: dir  input  1  0 = count up, 1 = count down; latched when start is accepted.
REQ-008 Port: abort  input  1  terminate the current sequence.
REQ-009 Port: g_ready  input  1  consumer ready to take g.
REQ-010 Port: g  output  WIDTH  Gray code of the internal binary register b, g = b XOR (b >> 1).
REQ-011 Port: g_valid  output  1  g holds a code offered to the consumer.
REQ-012 Port: busy  output  1  high in RUN and DONE.
REQ-013 Port: done  output  1  one-cycle pulse after the final code transfers.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-015 IDLE: start=1 with abort=0 SHALL load b<=b_start, rem<=len and dir_q<=dir, and move to RUN.
REQ-016 A transfer SHALL occur in any cycle with g_valid=1 and g_ready=1.
REQ-017 RUN: g_valid SHALL be 1, and g SHALL be valid in the first RUN cycle (one cycle after start is accepted).
REQ-018 RUN, transfer with rem!=0: the block SHALL set b<=b+1 (dir_q=0) or b<=b-1 (dir_q=1), modulo 2^WIDTH, and set rem<=rem-1.
REQ-019 RUN, transfer with rem==0: the block SHALL move to DONE and leave b unchanged.
REQ-020 RUN, g_valid=1 and g_ready=0: b, rem and g SHALL hold stable; no code is skipped or repeated.
REQ-021 Wrap-around: b SHALL pass all-ones to all-zeros when counting up, and all-zeros to all-ones when counting down; no other effect.
REQ-022 DONE: the state SHALL last exactly one cycle with done=1 and g_valid=0, then return to IDLE.
REQ-023 start SHALL be ignored in RUN and DONE; b_start, len and dir changes in those states SHALL have no effect.
REQ-024 abort=1 in RUN SHALL force IDLE on the next edge, with g_valid=0, busy=0 and no done pulse.
REQ-025 abort=1 in DONE SHALL leave the done pulse intact.
REQ-026 abort and start both high in IDLE: abort SHALL win and the block SHALL stay in IDLE.
REQ-027 In IDLE, g SHALL continue to reflect the last b and g_valid SHALL be 0.
REQ-028 len=0 SHALL emit exactly one code.
REQ-029 len=2^WIDTH-1 SHALL emit 2^WIDTH codes, ending one step before b_start, each code used exactly once.
REQ-030 Successive transferred codes SHALL differ in exactly one bit.
REQ-031 g_valid, busy and done SHALL be driven from registers; g SHALL depend only on registered b, with no input-to-output combinational path.

Reset
REQ-032 rst=1 SHALL set state=IDLE, b=0, rem=0, dir_q=0, g=0, g_valid=0, busy=0 and done=0 on the next edge.
REQ-033 rst SHALL override start, abort and any transfer in the same cycle.
REQ-034 rst asserted mid-sequence SHALL emit no further codes and no done pulse.

Verification (WIDTH=4)
REQ-035 Up count, no backpressure: start, b_start=0, len=3, dir=0, g_ready=1 -> g = 0000, 0001, 0011, 0010 on four consecutive valid cycles, then done=1 for one cycle, then busy=0.
REQ-036 Up count with wrap: b_start=14, len=2, dir=0 -> g = 1001, 1000, 0000, then done.
REQ-037 Down count with wrap: b_start=1, len=2, dir=1 -> g = 0001, 0000, 1000, then done.
REQ-038 Backpressure: as REQ-035, but g_ready=0 for 3 cycles while g=0001 -> g holds 0001 with g_valid=1 for 4 cycles; the sequence then resumes with 0011 and 0010, and no code is lost.
REQ-039 Abort and ignored start: abort after the second transfer -> g_valid=0 and busy=0 next cycle, no done; a start pulsed mid-RUN -> ignored, and sequence length is unchanged.
REQ-040 Reset mid-run: rst=1 during RUN -> next cycle g=0000, g_valid=0, busy=0 and done=0; with rst and start both high in IDLE -> state stays IDLE.

Source files
------------

// File: rtl/gray_seq_ctrl.sv
// gray_seq_ctrl
//   Emits a run of len+1 Gray codes. It starts from binary value b_start and
//   steps up or down by one, wrapping modulo 2^WIDTH. Each code is offered with
//   a valid/ready handshake.
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   start    begin a sequence (only accepted in IDLE; abort has priority)
//   b_start  binary value of the first code (latched on start)
//   len      number of codes minus one (latched on start)
//   dir      0 = count up, 1 = count down (latched on start)
//   abort    drop the current sequence without a done pulse
//   g_ready  consumer accepts g this cycle
//   g        Gray code of internal binary register b
//   g_valid  g is offered to the consumer
//   busy     sequence in progress (RUN or DONE)
//   done     one-cycle pulse after the final code transfers
module gray_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] b_start,
    input  logic [WIDTH-1:0] len,
    input  logic             dir,
    input  logic             abort,
    input  logic             g_ready,
    output logic [WIDTH-1:0] g,
    output logic             g_valid,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dir_q, dir_d;
    logic             g_valid_q, busy_q, done_q;

    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    b_d     = b_start;
                    rem_d   = len;
                    dir_d   = dir;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (g_ready) begin
                    if (rem_q == '0) begin
                        state_d = DONE;
                    end else begin
                        // Natural modulo-2^WIDTH arithmetic gives the wrap.
                        b_d   = dir_q ? b_q - WIDTH'(1) : b_q + WIDTH'(1);
                        rem_d = rem_q - WIDTH'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status flags are registered from the next state so they align with it
    // and have no combinational path from the inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            b_q       <= '0;
            rem_q     <= '0;
            dir_q     <= 1'b0;
            g_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            b_q       <= b_d;
            rem_q     <= rem_d;
            dir_q     <= dir_d;
            g_valid_q <= (state_d == RUN);
            busy_q    <= (state_d != IDLE);
            done_q    <= (state_d == DONE);
        end
    end

    assign g       = b_q ^ (b_q >> 1);
    assign g_valid = g_valid_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_gray_seq_ctrl.sv
module tb_gray_seq_ctrl;

    localparam int          W = 4;
    localparam int unsigned M = 1 << W;

    logic         clk = 1'b0;
    logic         rst, start, dir, abort, g_ready;
    logic [W-1:0] b_start, len, g;
    logic         g_valid, busy, done;

    gray_seq_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .b_start (b_start),
        .len     (len),
        .dir     (dir),
        .abort   (abort),
        .g_ready (g_ready),
        .g       (g),
        .g_valid (g_valid),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: phase (0 idle, 1 run, 2 done), queue of codes still to
    // be transferred, and the code currently presented.
    int           mode = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] cur_g = '0;
    // Codes actually transferred by the DUT in the current sequence.
    logic [W-1:0] dut_xfer[$];

    function automatic logic [W-1:0] gray(int unsigned v);
        int unsigned m;
        m = v % M;
        return W'(m ^ (m >> 1));
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: update the model from inputs seen at the edge, then compare.
    task automatic cyc();
        logic [W-1:0] obs_g;
        logic         obs_v;
        int unsigned  n;
        obs_g = g;
        obs_v = g_valid;
        @(posedge clk);
        if (!rst && obs_v && g_ready) begin
            if (dut_xfer.size() > 0)
                chk("one_bit_step", 32'($countones(obs_g ^ dut_xfer[$])), 32'd1);
            dut_xfer.push_back(obs_g);
        end
        if (rst) begin
            mode = 0;
            exp_q.delete();
            cur_g = '0;
        end else begin
            case (mode)
                0: if (start && !abort) begin
                    exp_q.delete();
                    dut_xfer.delete();
                    for (int unsigned k = 0; k <= 32'(len); k++) begin
                        n = dir ? 32'(b_start) + M - k : 32'(b_start) + k;
                        exp_q.push_back(gray(n));
                    end
                    cur_g = exp_q[0];
                    mode  = 1;
                end
                1: if (abort) begin
                    mode = 0;
                end else if (g_ready) begin
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) mode = 2;
                    else cur_g = exp_q[0];
                end
                default: mode = 0;
            endcase
        end
        #1;
        chk("g",       32'(g),       32'(cur_g));
        chk("g_valid", 32'(g_valid), 32'(mode == 1));
        chk("busy",    32'(busy),    32'(mode != 0));
        chk("done",    32'(done),    32'(mode == 2));
    endtask

    task automatic launch(logic [W-1:0] bs, logic [W-1:0] ln, logic d);
        b_start = bs; len = ln; dir = d; start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && mode != 0; i++) cyc();
        cyc();
        chk("drain_busy", 32'(busy), 32'd0);
    endtask

    task automatic chk_codes(string tag, logic [4*W-1:0] codes, int cnt);
        logic [W-1:0] e;
        chk({tag, "_count"}, 32'(dut_xfer.size()), 32'(cnt));
        for (int i = 0; i < cnt && i < dut_xfer.size(); i++) begin
            e = codes[(3-i)*W +: W];
            chk(tag, 32'(dut_xfer[i]), 32'(e));
        end
    endtask

    initial begin
        logic [M-1:0] seen;
        int           uniq;

        rst = 1'b1; start = 1'b0; abort = 1'b0; g_ready = 1'b0;
        dir = 1'b0; b_start = '0; len = '0;
        cyc();
        chk("reset_g", 32'(g), 32'd0);
        cyc();
        rst = 1'b0;
        cyc();

        // Up count, no backpressure.
        g_ready = 1'b1;
        launch(4'd0, 4'd3, 1'b0);
        drain();
        chk_codes("up", {4'b0000, 4'b0001, 4'b0011, 4'b0010}, 4);

        // Up count with wrap.
        launch(4'd14, 4'd2, 1'b0);
        drain();
        chk_codes("up_wrap", {4'b1001, 4'b1000, 4'b0000, 4'b0000}, 3);

        // Down count with wrap.
        launch(4'd1, 4'd2, 1'b1);
        drain();
        chk_codes("dn_wrap", {4'b0001, 4'b0000, 4'b1000, 4'b0000}, 3);

        // Backpressure while g=0001.
        launch(4'd0, 4'd3, 1'b0);
        cyc();
        g_ready = 1'b0;
        repeat (3) begin
            cyc();
            chk("bp_hold", 32'(g), 32'b0001);
        end
        g_ready = 1'b1;
        drain();
        chk_codes("bp", {4'b0000, 4'b0001, 4'b0011, 4'b0010}, 4);

        // Start pulsed mid-run with different parameters is ignored.
        launch(4'd0, 4'd3, 1'b0);
        cyc();
        b_start = 4'd9; len = 4'd7; dir = 1'b1; start = 1'b1;
        cyc();
        start = 1'b0;
        drain();
        chk_codes("ign_start", {4'b0000, 4'b0001, 4'b0011, 4'b0010}, 4);

        // Abort after the second transfer.
        launch(4'd0, 4'd7, 1'b0);
        cyc();
        cyc();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("abort_valid", 32'(g_valid), 32'd0);
        chk("abort_busy",  32'(busy),    32'd0);
        repeat (3) cyc();
        chk("abort_xfers", 32'(dut_xfer.size()), 32'd3);

        // Abort and start together in idle: stays idle.
        abort = 1'b1;
        launch(4'd5, 4'd2, 1'b0);
        abort = 1'b0;
        cyc();
        chk("abort_wins", 32'(busy), 32'd0);

        // Reset mid-run, then reset with start in idle.
        launch(4'd6, 4'd9, 1'b0);
        cyc();
        rst = 1'b1;
        cyc();
        chk("rst_g", 32'(g), 32'd0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        rst = 1'b0;
        repeat (2) cyc();
        chk("rst_idle_busy", 32'(busy), 32'd0);

        // Full-length sequences: every code exactly once.
        for (int t = 0; t < 2; t++) begin
            launch(W'($urandom_range(0, M - 1)), W'(M - 1), t[0]);
            drain();
            seen = '0;
            foreach (dut_xfer[i]) seen[dut_xfer[i]] = 1'b1;
            uniq = $countones(seen);
            chk("full_count",  32'(dut_xfer.size()), 32'(M));
            chk("full_unique", 32'(uniq),            32'(M));
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst     = ($urandom_range(0, 79) == 0);
            start   = ($urandom_range(0, 3) == 0);
            abort   = ($urandom_range(0, 19) == 0);
            g_ready = ($urandom_range(0, 2) != 0);
            dir     = 1'($urandom_range(0, 1));
            b_start = W'($urandom_range(0, M - 1));
            len     = W'($urandom_range(0, M - 1));
            cyc();
        end
        rst = 1'b0; start = 1'b0; abort = 1'b0; g_ready = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
